// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: framed serial bits into an N-bit word behind a valid/ready holding register.
// Optional even-parity bit per frame when SHIFT_DESER_PARITY_EN is defined.
module shift_deserializer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_start,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         shift_dir,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int unsigned CW = $clog2(N + 1);

`ifdef SHIFT_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;

  logic [N-1:0]  sr_base_c;
  logic          dir_use_c;
  logic [N-1:0]  shifted_c;
  logic          done_c;
  logic [N-1:0]  word_c;
  logic          perr_c;

  // A frame_start cycle shifts into a cleared register using the newly presented direction.
  always_comb begin
    sr_base_c = frame_start ? '0 : sr_q;
    dir_use_c = frame_start ? shift_dir : dir_q;
    if (dir_use_c) begin
      shifted_c = {serial_in, sr_base_c[N-1:1]};
    end else begin
      shifted_c = {sr_base_c[N-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state and frame completion detection.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_c  = 1'b0;
    word_c  = sr_q;
    perr_c  = 1'b0;

    if (frame_start) begin
      state_d = SHIFT;
      dir_d   = shift_dir;
      sr_d    = bit_valid ? shifted_c : '0;
      cnt_d   = bit_valid ? CW'(1) : '0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_valid) begin
            sr_d  = shifted_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
`ifdef SHIFT_DESER_PARITY_EN
              state_d = PARITY;
`else
              done_c  = 1'b1;
              word_c  = shifted_c;
              state_d = IDLE;
              cnt_d   = '0;
`endif
            end
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        PARITY: begin
          if (bit_valid) begin
            done_c  = 1'b1;
            word_c  = sr_q;
            perr_c  = (^sr_q) ^ serial_in;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Holding register: a completed word is dropped only if the held one is not being consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else if (done_c) begin
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else begin
        data_out   <= word_c;
        out_valid  <= 1'b1;
        parity_err <= perr_c;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed frames plus random traffic against a queue-based model.
// Parity-frame checks are included when SHIFT_DESER_PARITY_EN is defined.
module tb_shift_deserializer;
  localparam int unsigned N = 8;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int unsigned NB = N + 1;
`else
  localparam int unsigned NB = N;
`endif

  logic         clk;
  logic         reset;
  logic         frame_start;
  logic         serial_in;
  logic         bit_valid;
  logic         shift_dir;
  logic         out_ready;
  logic [N-1:0] data_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  shift_deserializer #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .shift_dir  (shift_dir),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the frame is a queue of received bits; words are built arithmetically.
  bit           q[$];
  bit           m_active, m_dir, m_valid, m_ovr, m_perr;
  logic [N-1:0] m_data;

  function automatic logic [N-1:0] assemble(input bit lsb_first);
    logic [N-1:0] w = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (q[i]) w = w | (N'(1) << (lsb_first ? i : (int'(N) - 1 - i)));
    end
    return w;
  endfunction

  task automatic model_clear();
    q.delete();
    m_active = 0; m_dir = 0; m_valid = 0; m_ovr = 0; m_perr = 0; m_data = '0;
  endtask

  task automatic model_edge();
    bit           done = 0;
    logic [N-1:0] w = '0;
    bit           pe = 0;
    if (frame_start) begin
      q.delete();
      m_active = 1;
      m_dir    = shift_dir;
      if (bit_valid) q.push_back(serial_in);
    end else if (m_active && bit_valid) begin
      q.push_back(serial_in);
      if (q.size() == NB) begin
        done = 1;
        m_active = 0;
        w = assemble(m_dir);
`ifdef SHIFT_DESER_PARITY_EN
        pe = (^w) ^ q[N];
`endif
      end
    end
    if (done) begin
      if (m_valid && !out_ready) m_ovr = 1;
      else begin
        m_data = w; m_valid = 1; m_perr = pe;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"},  32'(data_out),   32'(m_data));
    chk({tag, "_valid"}, 32'(out_valid),  32'(m_valid));
    chk({tag, "_busy"},  32'(busy),       32'(m_active));
    chk({tag, "_ovr"},   32'(overrun),    32'(m_ovr));
    chk({tag, "_perr"},  32'(parity_err), 32'(m_perr));
  endtask

  task automatic step(input bit fs, input bit si, input bit bv, input bit dir, input bit rdy);
    frame_start = fs; serial_in = si; bit_valid = bv; shift_dir = dir; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_data",  32'(data_out),   32'd0);
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ovr",   32'(overrun),    32'd0);
    chk("rst_perr",  32'(parity_err), 32'd0);
    model_clear();
    frame_start = 0; serial_in = 0; bit_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // First bit rides with frame_start; gap idle cycles precede every later bit.
  task automatic send_frame(input logic [N-1:0] word, input bit dir, input bit rdy,
                            input bit rdy_last, input int gap, input bit pbit);
    bit b;
    for (int i = 0; i < int'(NB); i++) begin
      if (i < int'(N)) b = dir ? word[i] : word[int'(N) - 1 - i];
      else b = pbit;
      if (i > 0) repeat (gap) step(0, 0, 0, dir, rdy);
      step(i == 0, b, 1, dir, (i == int'(NB) - 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 0; serial_in = 0; bit_valid = 0; shift_dir = 0; out_ready = 0;
    model_clear();
    do_reset();

    // MSB-first back-to-back bits with a ready consumer
    send_frame(8'hAA, 0, 1, 1, 0, 0);
    chk("t1_data",  32'(data_out),  32'hAA);
    chk("t1_valid", 32'(out_valid), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("t1_pulse", 32'(out_valid), 32'd0);

    // LSB-first with idle gaps between bits
    send_frame(8'hAA, 1, 1, 1, 2, 0);
    chk("t2_data", 32'(data_out), 32'hAA);
    step(0, 0, 0, 0, 1);

    // Stalled consumer: second word dropped, overrun sticky
    do_reset();
    send_frame(8'h3C, 0, 0, 0, 0, 0);
    chk("t3_data1", 32'(data_out), 32'h3C);
    send_frame(8'hC3, 0, 0, 0, 0, 0);
    chk("t3_data2", 32'(data_out), 32'h3C);
    chk("t3_ovr",   32'(overrun),  32'd1);
    step(0, 0, 0, 0, 1);
    chk("t3_valid", 32'(out_valid), 32'd0);
    chk("t3_ovr2",  32'(overrun),   32'd1);

    // Consume and reload on the same edge
    do_reset();
    send_frame(8'h11, 0, 0, 0, 0, 0);
    send_frame(8'h22, 0, 0, 1, 0, 0);
    chk("t4_data",  32'(data_out),  32'h22);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_ovr",   32'(overrun),   32'd0);
    step(0, 0, 0, 0, 1);

    // Abort mid-frame, then reset mid-frame
    step(1, 1, 1, 0, 1);
    repeat (4) step(0, 1, 1, 0, 1);
    send_frame(8'h5A, 0, 0, 0, 0, 0);
    chk("t5_data", 32'(data_out), 32'h5A);
    step(1, 1, 1, 0, 1);
    repeat (3) step(0, 0, 1, 0, 1);
    do_reset();
    send_frame(8'hF0, 0, 1, 1, 0, 0);
    chk("t5_f0", 32'(data_out), 32'hF0);

`ifdef SHIFT_DESER_PARITY_EN
    do_reset();
    send_frame(8'hAA, 0, 1, 1, 0, 0);
    chk("t6_perr0", 32'(parity_err), 32'd0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    for (int i = 1; i < int'(N); i++) step(0, ((8'hAB >> (7 - i)) & 1) != 0, 1, 0, 1);
    chk("t6_nine", 32'(out_valid), 32'd0);
    step(0, 0, 1, 0, 1);
    chk("t6_valid", 32'(out_valid),  32'd1);
    chk("t6_perr1", 32'(parity_err), 32'd1);
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
             1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
